// File: rtl/button_conditioner.sv
// Button front end: sync, debounce, press/auto-repeat detection and a conflict-free
// arbiter that produces one-cycle up/down/load commands for the downstream counter.

module button_conditioner_chan #(
   parameter int DEBOUNCE_BITS = 16,
   parameter int REPEAT_BITS   = 24,
   parameter int REPEAT_EN     = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic lvl_o,
   output logic cand_o
);
   typedef enum logic {IDLE, HELD} state_t;

   state_t                   state_q;
   logic                     sync0_q, sync1_q, lvl_q;
   logic [DEBOUNCE_BITS-1:0] cnt_q;
   logic [REPEAT_BITS-1:0]   rpt_q;
   logic                     accept, rise, fall, press_c, repeat_c;

   assign accept   = (sync1_q != lvl_q) && (&cnt_q);
   assign rise     = accept && !lvl_q;
   assign fall     = accept && lvl_q;
   assign press_c  = (state_q == IDLE) && rise;
   // A release landing on the wrap edge wins over the repeat.
   assign repeat_c = (REPEAT_EN != 0) && (state_q == HELD) && (&rpt_q) && !fall;
   assign cand_o   = press_c || repeat_c;
   assign lvl_o    = lvl_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
         rpt_q   <= '0;
         state_q <= IDLE;
      end else begin
         sync0_q <= raw_i;
         sync1_q <= sync0_q;
         if (sync1_q == lvl_q) begin
            cnt_q <= '0;
         end else if (&cnt_q) begin
            lvl_q <= sync1_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
         end
         case (state_q)
            IDLE: begin
               rpt_q <= '0;
               if (rise) state_q <= HELD;
            end
            HELD: begin
               if (fall) begin
                  state_q <= IDLE;
                  rpt_q   <= '0;
               end else begin
                  rpt_q <= (REPEAT_EN != 0) ? rpt_q + REPEAT_BITS'(1) : '0;
               end
            end
            default: begin
               state_q <= IDLE;
               rpt_q   <= '0;
            end
         endcase
      end
   end
endmodule

module button_conditioner #(
   parameter int DEBOUNCE_BITS = 16,
   parameter int REPEAT_BITS   = 24,
   parameter int AUTO_REPEAT   = 1
) (
   input  logic systemClock,
   input  logic resetButton,
   input  logic upButton,
   input  logic downButton,
   input  logic loadButton,
   output logic upPulse,
   output logic downPulse,
   output logic loadPulse,
   output logic upLevel,
   output logic downLevel,
   output logic loadLevel
);
   logic up_cand, down_cand, load_cand;
   logic up_pulse_q, down_pulse_q, load_pulse_q;

   button_conditioner_chan #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS), .REPEAT_BITS(REPEAT_BITS), .REPEAT_EN(AUTO_REPEAT)
   ) u_up (
      .clk_i(systemClock), .rst_i(resetButton), .raw_i(upButton),
      .lvl_o(upLevel), .cand_o(up_cand)
   );

   button_conditioner_chan #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS), .REPEAT_BITS(REPEAT_BITS), .REPEAT_EN(AUTO_REPEAT)
   ) u_down (
      .clk_i(systemClock), .rst_i(resetButton), .raw_i(downButton),
      .lvl_o(downLevel), .cand_o(down_cand)
   );

   button_conditioner_chan #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS), .REPEAT_BITS(REPEAT_BITS), .REPEAT_EN(0)
   ) u_load (
      .clk_i(systemClock), .rst_i(resetButton), .raw_i(loadButton),
      .lvl_o(loadLevel), .cand_o(load_cand)
   );

   // Load dominates; simultaneous up and down cancel. Losers are dropped.
   always_ff @(posedge systemClock) begin
      if (resetButton) begin
         up_pulse_q   <= 1'b0;
         down_pulse_q <= 1'b0;
         load_pulse_q <= 1'b0;
      end else begin
         load_pulse_q <= load_cand;
         up_pulse_q   <= up_cand && !down_cand && !load_cand;
         down_pulse_q <= down_cand && !up_cand && !load_cand;
      end
   end

   assign upPulse   = up_pulse_q;
   assign downPulse = down_pulse_q;
   assign loadPulse = load_pulse_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with small debounce/repeat widths: directed
// scenarios plus random button activity against a window/arithmetic reference model.

module tb_button_conditioner;
   localparam int DB = 2;
   localparam int RB = 3;
   localparam int N  = 1 << DB;
   localparam int R  = 1 << RB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, up_b = 1'b0, down_b = 1'b0, load_b = 1'b0;
   logic up_p, down_p, load_p, up_l, down_l, load_l;

   button_conditioner #(.DEBOUNCE_BITS(DB), .REPEAT_BITS(RB), .AUTO_REPEAT(1)) dut (
      .systemClock(clk), .resetButton(rst),
      .upButton(up_b), .downButton(down_b), .loadButton(load_b),
      .upPulse(up_p), .downPulse(down_p), .loadPulse(load_p),
      .upLevel(up_l), .downLevel(down_l), .loadLevel(load_l)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [5:0] exp_q[$];

   // Reference model: index 0 = up, 1 = down, 2 = load
   logic         m_p0[3], m_p1[3], m_lvl[3];
   logic [N-1:0] m_win[3];
   int           m_press[3];
   int           m_edge = 0;
   int           cnt_up, cnt_down, cnt_load;
   logic         rv[3];
   int           hold[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_edge);
      end
   endtask

   // Level flips once the last N synchronized samples all disagree with it;
   // repeats land on multiples of R edges after the press while still held.
   function automatic void model_step(input logic r, input logic [2:0] raw);
      logic cand[3];
      logic flip, rise, s;
      m_edge++;
      if (r) begin
         for (int b = 0; b < 3; b++) begin
            m_p0[b] = 1'b0; m_p1[b] = 1'b0; m_lvl[b] = 1'b0; m_win[b] = '0; m_press[b] = 0;
         end
         exp_q.push_back(6'b0);
      end else begin
         for (int b = 0; b < 3; b++) begin
            s = m_p1[b];
            m_p1[b] = m_p0[b];
            m_p0[b] = raw[b];
            m_win[b] = {m_win[b][N-2:0], s};
            flip = m_lvl[b] ? (m_win[b] == '0) : (m_win[b] == '1);
            rise = flip && !m_lvl[b];
            cand[b] = rise || (b < 2 && m_lvl[b] && !flip && ((m_edge - m_press[b]) % R == 0));
            if (rise) m_press[b] = m_edge;
            if (flip) m_lvl[b] = !m_lvl[b];
         end
         exp_q.push_back({cand[0] && !cand[1] && !cand[2],
                          cand[1] && !cand[0] && !cand[2],
                          cand[2], m_lvl[0], m_lvl[1], m_lvl[2]});
      end
   endfunction

   task automatic step(input logic r, input logic u, input logic d, input logic l);
      logic [5:0] exp;
      @(negedge clk);
      rst = r; up_b = u; down_b = d; load_b = l;
      @(posedge clk);
      model_step(r, {l, d, u});
      #1;
      exp = exp_q.pop_front();
      check("upPulse",   up_p,   exp[5]);
      check("downPulse", down_p, exp[4]);
      check("loadPulse", load_p, exp[3]);
      check("upLevel",   up_l,   exp[2]);
      check("downLevel", down_l, exp[1]);
      check("loadLevel", load_l, exp[0]);
      cnt_up   += int'(up_p);
      cnt_down += int'(down_p);
      cnt_load += int'(load_p);
   endtask

   task automatic do_reset();
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      cnt_up = 0; cnt_down = 0; cnt_load = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      do_reset();

      // Single press released so the fall coincides with the first repeat slot
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(20);
      check("s1_up_count", cnt_up, 1);
      check("s1_other_count", cnt_down + cnt_load, 0);

      // Bounce shorter than the debounce window
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, (i % 3) != 2, 1'b0, 1'b0);
      idle(10);
      check("s2_up_count", cnt_up, 0);

      // Auto-repeat
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(20);
      check("s3_up_count", cnt_up, 3);

      // Up and down together cancel
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      idle(20);
      check("s4_up_count", cnt_up, 0);
      check("s4_down_count", cnt_down, 0);

      // Load beats up; load does not repeat
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      idle(20);
      check("s5_load_count", cnt_load, 1);
      check("s5_up_count", cnt_up, 2);

      // Reset while held restarts debounce
      do_reset();
      for (int i = 1; i <= 30; i++) step(i == 10 || i == 11, 1'b0, 1'b1, 1'b0);
      idle(20);
      check("s6_down_count", cnt_down, 4);

      // Random activity with occasional resets
      do_reset();
      for (int b = 0; b < 3; b++) begin
         rv[b] = 1'b0;
         hold[b] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               rv[b] = 1'($urandom_range(0, 1));
               hold[b] = $urandom_range(1, 30);
            end
            hold[b]--;
         end
         step($urandom_range(0, 199) == 0, rv[0], rv[1], rv[2]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the three raw push-button inputs of the board (up, down, load) into clean single-cycle command pulses for the four-bit counter-with-load stage, which sits directly downstream. Each button passes through a two-flop synchronizer, a counter-based debouncer and a rising-edge detector. Up and down get optional auto-repeat while held. An arbiter guarantees the counter never sees conflicting commands in the same cycle.

## Interface
- DEBOUNCE_BITS, default 16: debounce counter width. A level change is accepted after 2^DEBOUNCE_BITS consecutive cycles of disagreement.
- REPEAT_BITS, default 24: repeat counter width. The auto-repeat period is 2^REPEAT_BITS cycles.
- AUTO_REPEAT, default 1: 1 enables auto-repeat on up and down; 0 gives one pulse per press only.

- systemClock  input  1  sole clock; all flops are on its rising edge
- resetButton  input  1  synchronous, active-high reset
- upButton  input  1  raw asynchronous up button, bouncy
- downButton  input  1  raw asynchronous down button, bouncy
- loadButton  input  1  raw asynchronous load button, bouncy
- upPulse  output  1  one-cycle increment command
- downPulse  output  1  one-cycle decrement command
- loadPulse  output  1  one-cycle load command
- upLevel  output  1  debounced level of upButton
- downLevel  output  1  debounced level of downButton
- loadLevel  output  1  debounced level of loadButton

## Operation
- **Per-button datapath** (three identical instances):
  - Synchronizer: sync0 then sync1.
  - Debounce counter `cnt` (DEBOUNCE_BITS wide) and stable level `lvl`.
- **Debounce rule, each edge:**
  - If sync1 == lvl: cnt <= 0.
  - Else if cnt == all-ones: lvl <= sync1 and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - Any single cycle of agreement restarts the count, so glitches shorter than 2^DEBOUNCE_BITS cycles are discarded.
- **Press candidate:** asserted on the edge where lvl goes 0 to 1. A 1 to 0 transition produces no pulse.
- **Repeat** (up and down only, when AUTO_REPEAT = 1):
  - Repeat counter `rpt` (REPEAT_BITS wide) is cleared on the press edge.
  - While lvl = 1, rpt increments each edge.
  - When rpt == all-ones, it wraps to 0 and raises a repeat candidate.
  - While lvl = 0, rpt is held at 0.
- **Per-button state machine:**
  - IDLE (lvl = 0) moves to HELD on the press edge.
  - HELD moves to IDLE when lvl falls.
  - Candidates are only generated in HELD or on entry to it.
- **Arbiter, registered with the pulses:**
  - A load candidate wins. loadPulse = 1, and upPulse and downPulse are forced to 0 that cycle.
  - If up and down candidates coincide with no load, both are suppressed and no pulse is issued.
  - Suppressed candidates are dropped, not queued.
  - Otherwise each candidate maps to its own pulse.
- **Outputs:** all pulses are exactly one cycle wide. Levels follow lvl.
- **Reset:**
  - While resetButton = 1, every flop clears (sync, cnt, lvl, rpt, FSM to IDLE, all outputs 0).
  - A button still held when reset releases is debounced afresh and produces a normal press pulse.
  - Reset asserted mid-debounce or mid-repeat discards that progress.

## Timing
- The raw input is sampled at edge k. The press pulse and the level rise are visible after edge k+1+2^DEBOUNCE_BITS.
- Release latency is the same: the level falls after edge k+1+2^DEBOUNCE_BITS.
- Press pulse to first repeat pulse: 2^REPEAT_BITS cycles. The period between repeats is the same.
- A repeat can fire on the same edge the level falls only if rpt was at all-ones. The fall takes precedence: no pulse.
- Pulses are registered outputs. The downstream counter acts on them at the next edge.

## Test plan
All scenarios use DEBOUNCE_BITS=2, REPEAT_BITS=3, AUTO_REPEAT=1. Edges are counted from the first edge sampling the stimulus.
1. Hold upButton high from reset release → outputs 0 during reset; upLevel rises and upPulse is high for exactly one cycle after edge 6. No downPulse or loadPulse.
2. upButton high for 3 cycles, then low; repeat as 2-on/1-off bursts for 20 cycles → upPulse and upLevel stay 0 throughout.
3. upButton high for 20 cycles → upPulse after edges 6, 14 and 22 (3 pulses); upLevel falls after edge 26; no further pulses.
4. upButton and downButton rise on the same cycle and are held 10 cycles → upLevel = downLevel = 1 after edge 6; no upPulse or downPulse. Repeats coincide on edge 14 and are also suppressed.
5. loadButton and upButton rise together and are held 20 cycles → loadPulse once after edge 6 with upPulse 0 there; upPulse at edges 14 and 22; loadPulse never repeats.
6. downButton held; resetButton pulsed high for 2 cycles at edge 10 → downLevel and pulses 0 during reset; a fresh downPulse 6 edges after reset release.
